// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing with trap and retire count.
// Latency: R-type 4, lw 5, sw 4, branch/jump 3, I-type 4 cycles with zero wait states; outputs decoded from state.
// Backpressure: FETCH holds on imem_ready=0, MEMRD/MEMWR hold on dmem_ready=0; ready is ignored elsewhere.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter bit EXT_ISA    = 1'b1,
    parameter bit TRAP_HALT  = 1'b1,
    parameter int RETIRE_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  imem_ready,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  imm_zext,
    output logic [1:0]            pc_src,
    output logic                  use_shamt,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic [3:0]            state,
    output logic [RETIRE_W-1:0]   retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd12,
        S_RST    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t                r_state;
    logic [RETIRE_W-1:0]   r_retired;
    state_t                w_dec_next;
    logic                  w_rtype_ok;
    logic                  w_shift;
    logic [3:0]            w_funct_alu;
    logic [3:0]            w_alu;

    // R-type funct decode: legality, ALU operation, and shift-amount operand select
    always_comb begin
        w_rtype_ok  = 1'b1;
        w_shift     = 1'b0;
        w_funct_alu = ALU_ADD;
        case (funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b100110: w_funct_alu = ALU_XOR;
            6'b100111: w_funct_alu = ALU_NOR;
            6'b101010: w_funct_alu = ALU_SLT;
            6'b000000: begin w_funct_alu = ALU_SLL; w_shift = 1'b1; end
            6'b000010: begin w_funct_alu = ALU_SRL; w_shift = 1'b1; end
            default:   w_rtype_ok = 1'b0;
        endcase
    end

    // Opcode dispatch out of DECODE; extended opcodes fall through to TRAP when disabled
    always_comb begin
        w_dec_next = S_TRAP;
        case (opcode)
            OP_RTYPE: w_dec_next = w_rtype_ok ? S_EXEC : S_TRAP;
            OP_LW,
            OP_SW:    w_dec_next = S_MEMADR;
            OP_BEQ:   w_dec_next = S_BRANCH;
            OP_BNE:   w_dec_next = EXT_ISA ? S_BRANCH : S_TRAP;
            OP_J:     w_dec_next = S_JUMP;
            OP_ADDI:  w_dec_next = S_IEXEC;
            OP_ANDI,
            OP_ORI,
            OP_SLTI:  w_dec_next = EXT_ISA ? S_IEXEC : S_TRAP;
            default:  w_dec_next = S_TRAP;
        endcase
    end

    // State sequencing and retire counting on the edge that leaves a completing state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RST;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_RST:    r_state <= S_FETCH;
                S_FETCH:  if (imem_ready) r_state <= S_DECODE;
                S_DECODE: r_state <= w_dec_next;
                S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (dmem_ready) r_state <= S_MEMWB;
                S_MEMWR: begin
                    if (dmem_ready) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + RETIRE_W'(1);
                    end
                end
                S_EXEC:   r_state <= S_ALUWB;
                S_IEXEC:  r_state <= S_IWB;
                S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + RETIRE_W'(1);
                end
                S_TRAP:   if (!TRAP_HALT) r_state <= S_FETCH;
                default:  r_state <= S_RST;
            endcase
        end
    end

    // Moore output decode; only the FETCH handshake strobes look at a ready input
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        imm_zext   = 1'b0;
        pc_src     = 2'd0;
        use_shamt  = 1'b0;
        illegal    = 1'b0;
        w_alu      = 4'b0000;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                w_alu     = ALU_ADD;
                pc_write  = imem_ready;
                ir_write  = imem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                w_alu     = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                w_alu     = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                w_alu     = w_funct_alu;
                use_shamt = w_shift;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                w_alu     = ALU_SUB;
                pc_src    = 2'd1;
                pc_write  = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_src   = 2'd2;
                pc_write = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                case (opcode)
                    OP_ANDI: begin w_alu = ALU_AND; imm_zext = 1'b1; end
                    OP_ORI:  begin w_alu = ALU_OR;  imm_zext = 1'b1; end
                    OP_SLTI: w_alu = ALU_SLT;
                    default: w_alu = ALU_ADD;
                endcase
            end
            S_IWB:   reg_write = 1'b1;
            S_TRAP:  illegal   = 1'b1;
            default: ;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(w_alu);
    assign state       = r_state;
    assign retired     = r_retired;

endmodule
